mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Bus target at the far end of the CPU MEM-stage data bus; answers word-granular Addr/As_/RW/WrData requests.
- Returns RdData plus an active-low ready strobe Rdy_.
- Backed by an internal word-addressed storage array with a programmable number of wait states, so pipeline stall behaviour can be exercised against a realistic slow memory.
- Out-of-range addresses complete with an error flag instead of touching storage.

Parameters:
- ADDR_W, 30, word address width (matches the word address bus).
- DATA_W, 32, word data width.
- DEPTH_LOG2, 10, log2 of implemented words (1024); valid when Addr < 2**DEPTH_LOG2.
- WAIT_CYCLES, 1, wait states inserted between request capture and ready; legal range 0..15.

Ports:
- Clk  in  1  single clock; all state changes on rising edge.
- Reset_  in  1  asynchronous, active-low reset.
- Addr  in  ADDR_W  word address from initiator.
- As_  in  1  address strobe, active-low; initiator holds it low until Rdy_ is seen.
- RW  in  1  READ=0, WRITE=1; qualified by As_.
- WrData  in  DATA_W  write data; qualified by As_ and RW=WRITE.
- RdData  out  DATA_W  read data; valid only while Rdy_=0 on a read; 0 otherwise.
- Rdy_  out  1  ready, active-low, one-cycle pulse per completed access.
- Err  out  1  high with Rdy_ when the captured address is out of range.

Behaviour:
- Reset (Reset_=0, async): state=IDLE, Rdy_=1, Err=0, RdData=0, wait counter=0. Storage contents are not reset.
- All outputs are registered.
- IDLE: on a Clk edge with As_=0, capture Addr, RW and WrData.
  - WAIT_CYCLES=0: go to ACK.
  - Otherwise: load counter with WAIT_CYCLES-1 and go to WAIT.
  - As_ is sampled only in IDLE.
- WAIT:
  - If As_=1 (initiator abort): return to IDLE; no write, no Rdy_.
  - Else if counter==0: go to ACK.
  - Else decrement the counter.
- ACK, single cycle:
  - Rdy_=0.
  - In range, read: RdData = mem[captured addr].
  - In range, write: mem[captured addr] <= captured WrData on the edge leaving ACK; RdData=0.
  - Out of range: Err=1, RdData=0, no storage access.
  - Next state is always IDLE.
- Latency from As_ first sampled low to the Rdy_=0 cycle is WAIT_CYCLES+1 cycles.
- Minimum access period is WAIT_CYCLES+2 cycles, because of the mandatory IDLE cycle after ACK.
- Back-to-back transfers: the initiator must change to the next request, or release As_, in the cycle after Rdy_=0. As_ still low in IDLE is treated as a new request.
- Range check uses the full captured Addr: any nonzero bit at or above DEPTH_LOG2 means out of range.
- RW or WrData changing during WAIT has no effect; the captured values are used.
- Reset mid-access:
  - A pending write is dropped.
  - Rdy_ returns to 1 immediately (asynchronously).
  - Storage keeps its prior contents.
- A read in the cycle after a write to the same address returns the new data; the write commits before the next capture can complete.
- Rdy_ and Err are never asserted outside ACK. Err=1 implies Rdy_=0.

Test Plan:
- WAIT_CYCLES=1: write 0xDEADBEEF at Addr 0x10, then read Addr 0x10.
  - Write: Rdy_=0 exactly 2 cycles after As_ first sampled low; Err=0; RdData=0.
  - Read: Rdy_=0 2 cycles after capture with RdData=0xDEADBEEF.
- WAIT_CYCLES=0: back-to-back read requests to 0x00, 0x01, 0x02 holding As_ low.
  - Rdy_ pulses every 2nd cycle.
  - RdData returns the preloaded values in order.
- Write to Addr 0x400 (DEPTH_LOG2=10).
  - Rdy_=0 and Err=1 in the ACK cycle; RdData=0.
  - A subsequent read of 0x000 returns its unchanged old value (no alias write).
- WAIT_CYCLES=3: write 0x12345678 to 0x20, releasing As_ after 2 cycles in WAIT.
  - No Rdy_ pulse.
  - A later read of 0x20 returns the prior value.
- Reset_ pulsed low during WAIT of a write of 0xCAFEF00D to 0x30.
  - Rdy_=1 and Err=0 immediately.
  - After release, a read of 0x30 returns the pre-reset contents.
- Read to 0x05 with WrData and RW toggled during WAIT.
  - The access completes as a read of 0x05 with correct data; storage is unchanged.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Word-addressed bus target with programmable wait states; answers As_/RW requests
// with a one-cycle active-low Rdy_ pulse and flags out-of-range addresses with Err.
module mem_bus_responder #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset_,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              As_,
  input  logic              RW,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              Rdy_,
  output logic              Err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              ack_nx;
  logic [ADDR_W-1:0] addr_p0;
  logic              rw_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_rw;
  logic              acc_ok;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >> DEPTH_LOG2) == '0;
  endfunction

  always_ff @(posedge Clk or negedge Reset_) begin
    if (!Reset_) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ack_nx   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!As_) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = S_ACK;
            ack_nx   = 1'b1;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        // Initiator abort wins over expiry of the wait count.
        if (As_) begin
          state_nx = S_IDLE;
        end else if (cnt == 4'd0) begin
          state_nx = S_ACK;
          ack_nx   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // With zero wait states the access is answered straight from the live bus.
  always_comb begin
    acc_addr = (state == S_IDLE) ? Addr : addr_p0;
    acc_rw   = (state == S_IDLE) ? RW   : rw_p0;
    acc_ok   = in_range(acc_addr);
    rd_word  = mem[acc_addr[DEPTH_LOG2-1:0]];
  end

  // p0: request capture
  always_ff @(posedge Clk) begin
    if (state == S_IDLE && !As_) begin
      addr_p0  <= Addr;
      rw_p0    <= RW;
      wdata_p0 <= WrData;
    end
  end

  // Write commits on the edge leaving ACK; a reset in ACK clears state first.
  always_ff @(posedge Clk) begin
    if (state == S_ACK && rw_p0 && in_range(addr_p0))
      mem[addr_p0[DEPTH_LOG2-1:0]] <= wdata_p0;
  end

  // p1: registered response
  always_ff @(posedge Clk or negedge Reset_) begin
    if (!Reset_) begin
      Rdy_   <= 1'b1;
      Err    <= 1'b0;
      RdData <= '0;
    end else begin
      Rdy_   <= !ack_nx;
      Err    <= ack_nx && !acc_ok;
      RdData <= (ack_nx && acc_ok && !acc_rw) ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench for mem_bus_responder: three instances (0, 1 and 3 wait states)
// checked against a per-instance word-array model of the bus protocol.
module tb_mem_bus_responder;

  logic        clk;
  logic        rst_n;
  logic [29:0] addr_s [3];
  logic        as_s   [3];
  logic        rw_s   [3];
  logic [31:0] wd_s   [3];
  logic [31:0] rd_s   [3];
  logic        rdy_s  [3];
  logic        err_s  [3];

  logic [31:0] mdl   [3][1024];
  bit          known [3][1024];

  int n_cmp = 0;
  int n_mis = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_responder #(
      .ADDR_W(30), .DATA_W(32), .DEPTH_LOG2(10),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .Clk(clk), .Reset_(rst_n), .Addr(addr_s[g]), .As_(as_s[g]), .RW(rw_s[g]),
      .WrData(wd_s[g]), .RdData(rd_s[g]), .Rdy_(rdy_s[g]), .Err(err_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access on instance i. bb: previous access held As_ low (back-to-back).
  // abort >= 0: release As_ that many cycles after capture. toggle: scramble RW/WrData after capture.
  task automatic access(input int i, input logic [29:0] a, input logic rw, input logic [31:0] wd,
                        input bit bb, input bit hold, input int abort, input bit toggle);
    int  lat;
    bit  seen;
    bit  oor;
    oor  = (a >> 10) != 0;
    addr_s[i] = a; rw_s[i] = rw; wd_s[i] = wd; as_s[i] = 1'b0;
    seen = 0; lat = -1;
    for (int k = 0; k < 24 && !seen; k++) begin
      @(posedge clk); #1;
      if (rdy_s[i] == 1'b0) begin
        seen = 1; lat = k;
      end else begin
        check($sformatf("quiet_i%0d", i), {31'h0, err_s[i], rd_s[i]}, 64'h0);
        if (toggle && k >= int'(bb)) begin
          rw_s[i] = ~rw_s[i];
          wd_s[i] = $urandom;
        end
        if (abort >= 0 && k == int'(bb) + abort) as_s[i] = 1'b1;
      end
    end
    if (abort >= 0) begin
      check($sformatf("abort_no_rdy_i%0d", i), 64'(seen), 64'h0);
      as_s[i] = 1'b1;
      return;
    end
    check($sformatf("latency_i%0d", i), 64'(lat), 64'(wc(i) + int'(bb)));
    if (!seen) begin
      as_s[i] = 1'b1;
      return;
    end
    check($sformatf("err_i%0d_a%0h", i, a), 64'(err_s[i]), 64'(oor));
    if (rw || oor)
      check($sformatf("rd_zero_i%0d_a%0h", i, a), 64'(rd_s[i]), 64'h0);
    else if (known[i][a[9:0]])
      check($sformatf("rd_data_i%0d_a%0h", i, a), 64'(rd_s[i]), 64'(mdl[i][a[9:0]]));
    if (rw && !oor) begin
      mdl[i][a[9:0]]   = wd;
      known[i][a[9:0]] = 1;
    end
    if (!hold) begin
      as_s[i] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("rdy_pulse_i%0d", i), 64'(rdy_s[i]), 64'h1);
    end
  endtask

  initial begin
    logic [29:0] a;
    logic [31:0] old30, old07;
    int          cur, ab;
    bit          bb, hold;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      as_s[i] = 1'b1; rw_s[i] = 1'b0; addr_s[i] = '0; wd_s[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_i%0d", i), {30'h0, rdy_s[i], err_s[i], rd_s[i]}, {30'h0, 2'b10, 32'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload a known window in every instance
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 64; w++)
        access(i, 30'(w), 1'b1, $urandom, 0, 0, -1, 0);

    // One wait state: write then read back
    access(1, 30'h10, 1'b1, 32'hDEADBEEF, 0, 0, -1, 0);
    access(1, 30'h10, 1'b0, 32'h0, 0, 0, -1, 0);
    check("deadbeef_model", 64'(mdl[1][16]), 64'hDEADBEEF);

    // Zero wait states, back-to-back reads with As_ held low
    access(0, 30'h0, 1'b0, 32'h0, 0, 1, -1, 0);
    access(0, 30'h1, 1'b0, 32'h0, 1, 1, -1, 0);
    access(0, 30'h2, 1'b0, 32'h0, 1, 0, -1, 0);

    // Out-of-range write must not alias onto word 0
    access(1, 30'h400, 1'b1, $urandom, 0, 0, -1, 0);
    access(1, 30'h0, 1'b0, 32'h0, 0, 0, -1, 0);

    // Aborted write after two WAIT cycles
    access(2, 30'h20, 1'b1, 32'h12345678, 0, 0, 1, 0);
    access(2, 30'h20, 1'b0, 32'h0, 0, 0, -1, 0);

    // Reset while inst2 waits and inst0 sits in ACK with a pending write
    old30 = mdl[2][48];
    old07 = mdl[0][7];
    addr_s[2] = 30'h30; rw_s[2] = 1'b1; wd_s[2] = 32'hCAFEF00D; as_s[2] = 1'b0;
    addr_s[0] = 30'h07; rw_s[0] = 1'b1; wd_s[0] = ~old07;       as_s[0] = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_ack_i0", 64'(rdy_s[0]), 64'h0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("async_reset_i%0d", i), {31'h0, rdy_s[i], err_s[i], rd_s[i]}, {31'h0, 2'b10, 32'h0});
    as_s[0] = 1'b1; as_s[2] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(2, 30'h30, 1'b0, 32'h0, 0, 0, -1, 0);
    access(0, 30'h07, 1'b0, 32'h0, 0, 0, -1, 0);
    check("reset_keeps_30", 64'(mdl[2][48]), 64'(old30));

    // Read with RW/WrData scrambled during WAIT, then confirm storage untouched
    access(2, 30'h05, 1'b0, $urandom, 0, 0, -1, 1);
    access(2, 30'h05, 1'b0, 32'h0, 0, 0, -1, 0);

    // Random traffic
    bb = 0; cur = 0;
    for (int n = 0; n < 150; n++) begin
      if (!bb) cur = $urandom_range(0, 2);
      a = 30'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a[10 + $urandom_range(0, 19)] = 1'b1;
      hold = ($urandom_range(0, 3) == 0) && (n != 149);
      ab = (wc(cur) > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, wc(cur) - 1) : -1;
      access(cur, a, 1'($urandom_range(0, 1)), $urandom, bb, hold, ab, 1'($urandom_range(0, 1)));
      bb = hold && (ab < 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
